// File: rtl/corner_stabilizer.sv
// corner_stabilizer
//   Qualifies raw per-frame quad-corner candidates from the marker detector
//   over time (search, acquire, lock, coast) and drives the perspective
//   generator. It emits at most one o_addr_valid pulse per frame, so the
//   generator only recomputes its coefficients on stable, sane corners.
// Ports
//   i_clk, i_rst_n         clock, async active-low reset
//   i_frame_end            1-cycle pulse, candidates valid this cycle
//   i_found                detector saw all four markers
//   i_{ul,ur,dl,dr}_addr   candidate corners {row[19:10], col[9:0]}
//   i_clear                synchronous force-unlock
//   o_addr_valid           1-cycle pulse: o_enable / addresses updated
//   o_enable               warp active with held corners
//   o_{ul,ur,dl,dr}_addr   held corners, same packing
//   o_locked               state is LOCKED or COAST
//   o_state                0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 COAST
module corner_stabilizer #(
   parameter int LOCK_FRAMES = 4,
   parameter int MISS_MAX    = 3,
   parameter int ACQ_TOL     = 8,
   parameter int TRACK_TOL   = 48,
   parameter int SHIFT       = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_end,
   input  logic        i_found,
   input  logic [19:0] i_ul_addr,
   input  logic [19:0] i_ur_addr,
   input  logic [19:0] i_dl_addr,
   input  logic [19:0] i_dr_addr,
   input  logic        i_clear,
   output logic        o_addr_valid,
   output logic        o_enable,
   output logic [19:0] o_ul_addr,
   output logic [19:0] o_ur_addr,
   output logic [19:0] o_dl_addr,
   output logic [19:0] o_dr_addr,
   output logic        o_locked,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {S_SEARCH = 2'd0, S_ACQ = 2'd1, S_LOCKED = 2'd2, S_COAST = 2'd3} state_t;

   localparam logic [3:0]  LF = 4'(LOCK_FRAMES);
   localparam logic [3:0]  MM = 4'(MISS_MAX);
   localparam logic [10:0] AT = 11'(ACQ_TOL);
   localparam logic [10:0] TT = 11'(TRACK_TOL);

   // corner index: 0 ul, 1 ur, 2 dl, 3 dr
   logic [3:0][19:0] r_cand, r_ref, r_held;
   logic             r_found, r_v1, r_v2, r_clr_pend;
   logic             r_enable, r_addr_valid;
   logic [3:0]       r_acq_cnt, r_miss_cnt;
   state_t           r_state;

   logic             w_accept, w_valid, w_acq_ok, w_trk_ok;
   logic [3:0][19:0] w_smooth;

   function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
   endfunction

   // held + (cand - held) >>> SHIFT in 11-bit signed; result lies between
   // held and cand, so truncating back to 10 bits is exact.
   function automatic logic [9:0] smooth(input logic [9:0] h, input logic [9:0] c);
      logic signed [10:0] d;
      logic signed [10:0] s;
      d = $signed({1'b0, c}) - $signed({1'b0, h});
      s = d >>> SHIFT;
      return 10'($signed({1'b0, h}) + s);
   endfunction

   // A frame is ignored while the previous one is still in flight (T+1, T+2)
   // and while a deferred clear pulse is pending.
   assign w_accept = i_frame_end & ~r_v1 & ~r_v2 & ~r_clr_pend & ~i_clear;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_cand  <= '0;
         r_found <= 1'b0;
      end else begin
         r_v1 <= w_accept;
         r_v2 <= r_v1;
         if (w_accept) begin
            r_cand  <= {i_dr_addr, i_dl_addr, i_ur_addr, i_ul_addr};
            r_found <= i_found;
         end
      end
   end

   always_comb begin
      w_valid  = r_found;
      w_acq_ok = 1'b1;
      w_trk_ok = 1'b1;
      w_smooth = '0;
      for (int i = 0; i < 4; i++) begin
         if (r_cand[i][19:10] >= 10'd600 || r_cand[i][9:0] >= 10'd800) w_valid = 1'b0;
         if (absdiff(r_cand[i][19:10], r_ref[i][19:10]) > AT ||
             absdiff(r_cand[i][9:0],   r_ref[i][9:0])   > AT) w_acq_ok = 1'b0;
         if (absdiff(r_cand[i][19:10], r_held[i][19:10]) > TT ||
             absdiff(r_cand[i][9:0],   r_held[i][9:0])   > TT) w_trk_ok = 1'b0;
         w_smooth[i] = {smooth(r_held[i][19:10], r_cand[i][19:10]),
                        smooth(r_held[i][9:0],   r_cand[i][9:0])};
      end
      if (!(r_cand[0][9:0]   < r_cand[1][9:0]   && r_cand[2][9:0]   < r_cand[3][9:0] &&
            r_cand[0][19:10] < r_cand[2][19:10] && r_cand[1][19:10] < r_cand[3][19:10]))
         w_valid = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_SEARCH;
         r_acq_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_ref        <= '0;
         r_held       <= '0;
         r_enable     <= 1'b0;
         r_addr_valid <= 1'b0;
         r_clr_pend   <= 1'b0;
      end else begin
         r_addr_valid <= 1'b0;
         if (r_clr_pend) begin
            // deferred clear: the previous cycle already carried a pulse
            r_clr_pend   <= 1'b0;
            r_enable     <= 1'b0;
            r_addr_valid <= 1'b1;
         end else if (i_clear) begin
            r_state    <= S_SEARCH;
            r_acq_cnt  <= '0;
            r_miss_cnt <= '0;
            if (r_enable) begin
               if (r_addr_valid) r_clr_pend <= 1'b1;
               else begin
                  r_enable     <= 1'b0;
                  r_addr_valid <= 1'b1;
               end
            end
         end else if (r_v1) begin
            case (r_state)
               S_SEARCH: if (w_valid) begin
                  r_ref     <= r_cand;
                  r_acq_cnt <= 4'd1;
                  r_state   <= S_ACQ;
               end
               S_ACQ: begin
                  if (!w_valid) begin
                     r_acq_cnt <= '0;
                     r_state   <= S_SEARCH;
                  end else if (w_acq_ok) begin
                     r_ref     <= r_cand;
                     r_acq_cnt <= r_acq_cnt + 4'd1;
                     if (r_acq_cnt + 4'd1 == LF) begin
                        r_held       <= r_cand;
                        r_enable     <= 1'b1;
                        r_addr_valid <= 1'b1;
                        r_miss_cnt   <= '0;
                        r_state      <= S_LOCKED;
                     end
                  end else begin
                     r_ref     <= r_cand;
                     r_acq_cnt <= 4'd1;
                  end
               end
               S_LOCKED: begin
                  if (w_valid && w_trk_ok) begin
                     r_held       <= w_smooth;
                     r_addr_valid <= 1'b1;
                  end else if (MISS_MAX == 1) begin
                     r_state      <= S_SEARCH;
                     r_acq_cnt    <= '0;
                     r_enable     <= 1'b0;
                     r_addr_valid <= 1'b1;
                  end else begin
                     r_miss_cnt <= 4'd1;
                     r_state    <= S_COAST;
                  end
               end
               default: begin // S_COAST
                  if (w_valid && w_trk_ok) begin
                     r_held       <= w_smooth;
                     r_miss_cnt   <= '0;
                     r_state      <= S_LOCKED;
                     r_addr_valid <= 1'b1;
                  end else if (r_miss_cnt + 4'd1 == MM) begin
                     r_miss_cnt   <= '0;
                     r_acq_cnt    <= '0;
                     r_state      <= S_SEARCH;
                     r_enable     <= 1'b0;
                     r_addr_valid <= 1'b1;
                  end else begin
                     r_miss_cnt <= r_miss_cnt + 4'd1;
                  end
               end
            endcase
         end
      end
   end

   assign o_addr_valid = r_addr_valid;
   assign o_enable     = r_enable;
   assign o_ul_addr    = r_held[0];
   assign o_ur_addr    = r_held[1];
   assign o_dl_addr    = r_held[2];
   assign o_dr_addr    = r_held[3];
   assign o_locked     = r_state[1];
   assign o_state      = r_state;

endmodule

// File: tb/tb_corner_stabilizer.sv
module tb_corner_stabilizer;
   logic        clk = 1'b0, rst_n = 1'b0, fe = 1'b0, found = 1'b0, clr = 1'b0;
   logic [19:0] ul = '0, ur = '0, dl = '0, dr = '0;
   logic        o_addr_valid, o_enable, o_locked;
   logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
   logic [1:0]  o_state;

   always #5 clk = ~clk;

   corner_stabilizer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_end(fe), .i_found(found),
      .i_ul_addr(ul), .i_ur_addr(ur), .i_dl_addr(dl), .i_dr_addr(dr),
      .i_clear(clr), .o_addr_valid(o_addr_valid), .o_enable(o_enable),
      .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr), .o_dl_addr(o_dl_addr),
      .o_dr_addr(o_dr_addr), .o_locked(o_locked), .o_state(o_state));

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] pk(input int r, input int c);
      return {10'(r), 10'(c)};
   endfunction

   // ---------------- behavioural reference model ----------------
   // Corners as integers [corner][0=row,1=col]; one step per clock edge.
   int m_state, m_acq, m_miss, m_en, m_pulse, m_pend, m_capv, m_capf, m_last, m_cyc;
   int m_ref[4][2], m_held[4][2], m_cap[4][2];

   task automatic m_reset();
      m_state = 0; m_acq = 0; m_miss = 0; m_en = 0; m_pulse = 0; m_pend = 0;
      m_capv = 0; m_capf = 0; m_last = -100; m_cyc = 0;
      for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) begin
         m_ref[k][j] = 0; m_held[k][j] = 0; m_cap[k][j] = 0;
      end
   endtask

   function automatic int floor_div4(input int d);
      return (d >= 0) ? d / 4 : -((-d + 3) / 4);
   endfunction

   function automatic bit m_valid();
      if (m_capf == 0) return 0;
      for (int k = 0; k < 4; k++)
         if (m_cap[k][0] >= 600 || m_cap[k][1] >= 800) return 0;
      return m_cap[0][1] < m_cap[1][1] && m_cap[2][1] < m_cap[3][1] &&
             m_cap[0][0] < m_cap[2][0] && m_cap[1][0] < m_cap[3][0];
   endfunction

   function automatic bit near(input int tol, input bit vs_held);
      for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) begin
         int d;
         d = m_cap[k][j] - (vs_held ? m_held[k][j] : m_ref[k][j]);
         if (d < 0) d = -d;
         if (d > tol) return 0;
      end
      return 1;
   endfunction

   task automatic m_smooth();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++)
         m_held[k][j] = m_held[k][j] + floor_div4(m_cap[k][j] - m_held[k][j]);
   endtask

   task automatic m_eval();
      bit v;
      v = m_valid();
      case (m_state)
         0: if (v) begin m_ref = m_cap; m_acq = 1; m_state = 1; end
         1: if (!v) begin m_acq = 0; m_state = 0; end
            else if (near(8, 0)) begin
               m_ref = m_cap; m_acq++;
               if (m_acq == 4) begin m_held = m_cap; m_en = 1; m_pulse = 1; m_state = 2; m_miss = 0; end
            end else begin m_ref = m_cap; m_acq = 1; end
         2: if (v && near(48, 1)) begin m_smooth(); m_pulse = 1; end
            else begin m_miss = 1; m_state = 3; end
         default:
            if (v && near(48, 1)) begin m_smooth(); m_miss = 0; m_state = 2; m_pulse = 1; end
            else begin
               m_miss++;
               if (m_miss == 3) begin m_state = 0; m_en = 0; m_pulse = 1; m_miss = 0; end
            end
      endcase
   endtask

   task automatic m_step();
      int old_pulse, old_pend;
      bit acc;
      old_pulse = m_pulse; old_pend = m_pend;
      acc = fe && !clr && old_pend == 0 && (m_cyc - m_last >= 3);
      m_pulse = 0;
      if (old_pend != 0) begin m_pend = 0; m_en = 0; m_pulse = 1; end
      else if (clr) begin
         m_state = 0; m_acq = 0; m_miss = 0;
         if (m_en != 0) begin
            if (old_pulse != 0) m_pend = 1;
            else begin m_en = 0; m_pulse = 1; end
         end
      end else if (m_capv != 0) m_eval();
      m_capv = acc;
      if (acc) begin
         m_last = m_cyc; m_capf = found;
         m_cap[0][0] = int'(ul[19:10]); m_cap[0][1] = int'(ul[9:0]);
         m_cap[1][0] = int'(ur[19:10]); m_cap[1][1] = int'(ur[9:0]);
         m_cap[2][0] = int'(dl[19:10]); m_cap[2][1] = int'(dl[9:0]);
         m_cap[3][0] = int'(dr[19:10]); m_cap[3][1] = int'(dr[9:0]);
      end
      m_cyc++;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset(); else m_step();
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic [79:0] exp_a;
      exp_a = {pk(m_held[0][0], m_held[0][1]), pk(m_held[1][0], m_held[1][1]),
               pk(m_held[2][0], m_held[2][1]), pk(m_held[3][0], m_held[3][1])};
      chk("m_addr_valid", o_addr_valid, 80'(m_pulse));
      chk("m_enable", o_enable, 80'(m_en));
      chk("m_state", o_state, 80'(m_state));
      chk("m_locked", o_locked, 80'(m_state >= 2));
      chk("m_addrs", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, exp_a);
   end

   // ---------------- stimulus ----------------
   localparam logic [19:0] B_UL = 20'h19064; // {100,100}
   localparam logic [19:0] B_UR = 20'h191F4; // {100,500}
   localparam logic [19:0] B_DL = 20'h64064; // {400,100}
   localparam logic [19:0] B_DR = 20'h641F4; // {400,500}

   // Drives one frame_end and returns at the negedge of cycle T+2.
   task automatic frame(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                        input logic [19:0] d, input logic f);
      @(negedge clk);
      ul = a; ur = b; dl = c; dr = d; found = f; fe = 1'b1;
      @(negedge clk);
      fe = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   initial begin
      int r0, c0, h, w, scene;
      repeat (2) @(negedge clk);
      chk("reset_state", o_state, 0);
      chk("reset_outs", {o_addr_valid, o_enable, o_locked, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, '0);
      rst_n = 1'b1;

      // 1: acquire and lock on identical frames
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      chk("t1_state_acq", o_state, 1);
      chk("t1_nopulse", o_addr_valid, 0);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      chk("t1_still_acq", o_state, 1);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      chk("t1_pulse", o_addr_valid, 1);
      chk("t1_enable", o_enable, 1);
      chk("t1_state_lock", o_state, 2);
      chk("t1_addrs", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, {B_UL, B_UR, B_DL, B_DR});
      @(negedge clk);
      chk("t1_single_pulse", o_addr_valid, 0);

      // 2: smoothing, 100 -> 140 gives 110
      frame(pk(100, 140), B_UR, B_DL, B_DR, 1);
      chk("t2_pulse", o_addr_valid, 1);
      chk("t2_ul", o_ul_addr, pk(100, 110));
      chk("t2_others", {o_ur_addr, o_dl_addr, o_dr_addr}, {B_UR, B_DL, B_DR});

      // 3: loss handling
      frame(B_UL, B_UR, B_DL, B_DR, 0);
      chk("t3_coast1", {o_state, o_addr_valid}, {2'd3, 1'b0});
      frame(B_UL, B_UR, B_DL, B_DR, 0);
      chk("t3_coast2", {o_state, o_addr_valid}, {2'd3, 1'b0});
      frame(B_UL, B_UR, B_DL, B_DR, 0);
      chk("t3_drop", {o_state, o_enable, o_addr_valid}, {2'd0, 1'b0, 1'b1});
      chk("t3_held", o_ul_addr, pk(100, 110));

      // 4: ACQ_TOL+1 restarts acquisition
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, pk(100, 509), B_DL, B_DR, 1);
      chk("t4_restart", o_state, 1);
      frame(B_UL, pk(100, 509), B_DL, B_DR, 1);
      frame(B_UL, pk(100, 509), B_DL, B_DR, 1);
      chk("t4_not_yet", o_state, 1);
      frame(B_UL, pk(100, 509), B_DL, B_DR, 1);
      chk("t4_lock", {o_state, o_addr_valid}, {2'd2, 1'b1});
      pulse_clear();
      chk("t4_clear", {o_state, o_enable, o_addr_valid}, {2'd0, 1'b0, 1'b1});
      // shift of exactly ACQ_TOL is accepted
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, pk(100, 508), B_DL, B_DR, 1);
      frame(B_UL, pk(100, 508), B_DL, B_DR, 1);
      chk("t4_eq_acq", o_state, 1);
      frame(B_UL, pk(100, 508), B_DL, B_DR, 1);
      chk("t4_eq_lock", {o_state, o_addr_valid, o_ur_addr}, {2'd2, 1'b1, pk(100, 508)});

      // 5: invalid geometry / row 600, then clear coincident with frame_end
      frame(pk(100, 500), pk(100, 100), B_DL, B_DR, 1);
      chk("t5_geom", {o_state, o_addr_valid}, {2'd3, 1'b0});
      frame(B_UL, pk(100, 508), pk(600, 100), B_DR, 1);
      chk("t5_row600", {o_state, o_addr_valid}, {2'd3, 1'b0});
      @(negedge clk);
      ul = B_UL; ur = B_UR; dl = B_DL; dr = B_DR; found = 1'b1; fe = 1'b1; clr = 1'b1;
      @(negedge clk);
      fe = 1'b0; clr = 1'b0;
      chk("t5_clr", {o_state, o_enable, o_addr_valid}, {2'd0, 1'b0, 1'b1});
      @(negedge clk);
      chk("t5_clr_T2", {o_state, o_addr_valid}, {2'd0, 1'b0});
      frame(B_UL, B_UR, pk(600, 100), B_DR, 1);
      chk("t5_row600_search", o_state, 0);

      // 6: reset in the middle of an evaluation
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      chk("t6_prelock", o_state, 2);
      @(negedge clk);
      fe = 1'b1;
      @(negedge clk);
      fe = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("t6_rst_outs", {o_addr_valid, o_enable, o_locked, o_state, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_after", {o_state, o_addr_valid}, {2'd0, 1'b0});
      frame(B_UL, B_UR, B_DL, B_DR, 1);
      chk("t6_acq", {o_state, o_addr_valid}, {2'd1, 1'b0});

      // randomized phase: jittered scenes, random frame spacing, clears, misses
      scene = 0; r0 = 100; c0 = 100; h = 200; w = 300;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (cyc >= scene) begin
            scene = cyc + int'($urandom_range(150, 500));
            r0 = int'($urandom_range(20, 300)); c0 = int'($urandom_range(20, 300));
            h = int'($urandom_range(100, 250)); w = int'($urandom_range(100, 450));
         end
         fe    = ($urandom_range(0, 2) == 0);
         clr   = ($urandom_range(0, 99) == 0);
         found = ($urandom_range(0, 11) != 0);
         ul = pk(r0 + int'($urandom_range(0, 6)) - 3, c0 + int'($urandom_range(0, 6)) - 3);
         ur = pk(r0 + int'($urandom_range(0, 6)) - 3, c0 + w + int'($urandom_range(0, 6)) - 3);
         dl = pk(r0 + h + int'($urandom_range(0, 6)) - 3, c0 + int'($urandom_range(0, 6)) - 3);
         dr = pk(r0 + h + int'($urandom_range(0, 6)) - 3, c0 + w + int'($urandom_range(0, 6)) - 3);
         if ($urandom_range(0, 19) == 0) ul = pk(r0, c0 + int'($urandom_range(0, 80)));
         if ($urandom_range(0, 29) == 0) dr = pk(int'($urandom_range(595, 610)), c0 + w);
         if ($urandom_range(0, 39) == 0) ul = pk(r0, c0 + w + 5);
      end
      fe = 1'b0; clr = 1'b0;
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/corner_stabilizer.md
Name: corner_stabilizer

Overview:
- Sits directly upstream of the perspective image generator.
- Takes the raw per-frame quad-corner candidates from the marker detector and qualifies them over time: acquisition, lock, temporal smoothing and loss handling.
- Drives the generator's corner-address, address-valid and enable inputs.
- Emits at most one address-valid pulse per frame, so the generator recomputes its perspective coefficients only on stable, sane corners.

Parameters:
LOCK_FRAMES, 4, consecutive consistent frames needed to lock (2..15)
MISS_MAX, 3, consecutive bad frames while locked before dropping lock (1..15)
ACQ_TOL, 8, max per-coordinate delta (pixels) between frames during acquisition
TRACK_TOL, 48, max per-coordinate delta (pixels) from held corner while tracking
SHIFT, 2, IIR smoothing shift; held += (cand - held) >>> SHIFT

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_end  in  1  one-cycle pulse: candidates for the finished frame are valid this cycle
i_found  in  1  detector found all four markers this frame
i_ul_addr  in  20  candidate upper-left {row[19:10], col[9:0]}
i_ur_addr  in  20  candidate upper-right
i_dl_addr  in  20  candidate lower-left
i_dr_addr  in  20  candidate lower-right
i_clear  in  1  synchronous force-unlock
o_addr_valid  out  1  one-cycle pulse: o_enable and addresses updated
o_enable  out  1  1 = warp active with held corners
o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr  out  20 each  held corners, same packing
o_locked  out  1  state is LOCKED or COAST
o_state  out  2  0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 COAST

Behaviour:
- Reset: state SEARCH; all outputs 0; acq_cnt=0; miss_cnt=0; reference corners=0.
- i_frame_end sampled high at cycle T:
  - Candidates registered at T+1.
  - Validity and distance flags computed at T+1.
  - State, held corners and o_enable update at T+2.
  - o_addr_valid high during T+2 only, when a pulse is required.
- i_frame_end pulses arriving at T+1 or T+2 are ignored.
- Valid candidate requires all of:
  - i_found=1
  - every row < 600 and every col < 800
  - ul.col < ur.col, dl.col < dr.col, ul.row < dl.row, ur.row < dr.row
- Delta: unsigned |cand - ref| per row and col field, 11-bit. A frame passes if all 8 deltas <= tolerance. An equal delta passes.
- SEARCH:
  - Valid frame: ref=cand, acq_cnt=1, go ACQUIRE. No pulse.
- ACQUIRE:
  - Valid and within ACQ_TOL of ref: ref=cand, acq_cnt+1. If the new count equals LOCK_FRAMES: held=cand, o_enable=1, pulse, go LOCKED, miss_cnt=0.
  - Valid but outside ACQ_TOL: ref=cand, acq_cnt=1.
  - Invalid: acq_cnt=0, go SEARCH.
  - No pulse unless locking.
- LOCKED:
  - Valid and within TRACK_TOL of held: each field held += (cand-held)>>>SHIFT. This is 11-bit signed arithmetic shift rounding toward -inf. The result always lies between held and cand, so no clamp is needed. Pulse with o_enable=1.
  - Otherwise: miss_cnt=1, go COAST, held unchanged, no pulse. With MISS_MAX=1, go directly to SEARCH instead, with o_enable=0 and a pulse.
- COAST:
  - Valid and within TRACK_TOL: smooth as above, miss_cnt=0, go LOCKED, pulse.
  - Otherwise miss_cnt+1. When it reaches MISS_MAX: go SEARCH, o_enable=0, pulse; held addresses keep their last values.
- i_clear:
  - Next cycle: state SEARCH, counters 0.
  - If o_enable was 1: o_enable=0 and a one-cycle pulse, otherwise no pulse.
  - Clear wins over any in-flight frame evaluation, which is discarded.
- o_addr_valid never high on two consecutive cycles. Addresses and o_enable are stable from the pulse until the next pulse.
- Async reset mid-evaluation discards the evaluation; outputs are 0 immediately.

Test Plan:
1. Four frame_end pulses with identical valid corners (ul {100,100}, ur {100,500}, dl {400,100}, dr {400,500}) -> state 1 after frame 1. On frame 4 at T+2: single pulse, o_enable=1, outputs equal inputs, o_state=2.
2. While locked, ul col moves 100 -> 140 -> one pulse; o_ul_addr col=110. Other corners unchanged.
3. While locked, three frames with i_found=0 -> states 3,3 with no pulse, then state 0 with o_enable=0 and one pulse. Held addresses unchanged.
4. In ACQUIRE, frame 2 has ur col shifted by 9 (ACQ_TOL+1) -> acq_cnt resets to 1, state stays 1. Lock happens only after 3 further consistent frames. A shift of exactly 8 is accepted.
5. Geometry violation (ul col 500, ur col 100) or row=600 -> treated as invalid. Also: i_clear coincident with i_frame_end while locked -> next cycle o_enable=0 with one pulse, state 0, no second pulse at T+2.
6. Reset asserted at T+1 of an evaluation -> all outputs 0, state 0. After release, the next frame behaves as from SEARCH.
